// File: rtl/mask_ser_pkg.sv
// Shared types and helpers for the mask stream serializer: row-width modes,
// FSM states, per-mode step size and beat-counter width.
package mask_ser_pkg;

    typedef enum logic [1:0] {
        MODE_320     = 2'd0,
        MODE_640     = 2'd1,
        MODE_1080    = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Sized for the widest default row (1080 / 20 = 54 beats).
    localparam int MAX_STEP = 1080 / 20;
    localparam int CNT_W    = $clog2(MAX_STEP + 1);

    function automatic int step_of(input logic [1:0] mode, input int w0, input int w1,
                                   input int w2, input int op_w);
        case (mode)
            MODE_640:  return w1 / op_w;
            MODE_1080: return w2 / op_w;
            default:   return w0 / op_w;
        endcase
    endfunction

endpackage

// File: rtl/mask_stream_serializer_lane_tap.sv
// Strided lane tap: lane i of the beat reads the shift register at i*S, where
// S is the step of the row's latched mode.
module mask_lane_tap
    import mask_ser_pkg::*;
#(
    parameter int IP_W = 1080,
    parameter int OP_W = 20,
    parameter int W0   = 320,
    parameter int W1   = 640,
    parameter int W2   = 1080
) (
    input  logic [IP_W-1:0] sh_i,
    input  logic [1:0]      mode_i,
    output logic [OP_W-1:0] data_o
);

    localparam int S0 = W0 / OP_W;
    localparam int S1 = W1 / OP_W;
    localparam int S2 = W2 / OP_W;

    logic [OP_W-1:0] tap0;
    logic [OP_W-1:0] tap1;
    logic [OP_W-1:0] tap2;
    // Most shift-register bits only pass through on their way to a tap.
    logic            unused_sh;

    for (genvar i = 0; i < OP_W; i++) begin : g_lane
        assign tap0[i] = sh_i[i*S0];
        assign tap1[i] = sh_i[i*S1];
        assign tap2[i] = sh_i[i*S2];
    end

    always_comb begin
        case (mode_i)
            MODE_640:  data_o = tap1;
            MODE_1080: data_o = tap2;
            default:   data_o = tap0;
        endcase
    end

    assign unused_sh = ^sh_i;

endmodule

// File: rtl/mask_stream_serializer.sv
// Serializes one wide mask row into strided OP_W-bit beats with first/last
// framing. Define MASK_SER_PINGPONG_EN to add a shadow row buffer (no bubble).
module mask_stream_serializer
    import mask_ser_pkg::*;
#(
    parameter int IP_W = 1080,
    parameter int OP_W = 20,
    parameter int W0   = 320,
    parameter int W1   = 640,
    parameter int W2   = 1080
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IP_W-1:0] in_data,
    input  logic [1:0]      in_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_data,
    output logic            out_first,
    output logic            out_last,
    output logic            busy,
    output logic            err
);

    state_e           state_q, state_d;
    logic [IP_W-1:0]  sh_q, sh_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_cnt;
    logic             err_q, err_d;
    logic [OP_W-1:0]  tap_data;
    logic             in_fire, in_legal, out_fire, last_fire;

`ifdef MASK_SER_PINGPONG_EN
    logic             shadow_full_q, shadow_full_d;
    logic [IP_W-1:0]  shadow_q, shadow_d;
    logic [1:0]       shadow_mode_q, shadow_mode_d;

    assign in_ready = !shadow_full_q;
    assign busy     = (state_q == SHIFT) || shadow_full_q;
`else
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == SHIFT);
`endif

    assign in_fire   = in_valid && in_ready;
    assign in_legal  = (in_mode != MODE_ILLEGAL);
    assign out_valid = (state_q == SHIFT);
    assign out_fire  = out_valid && out_ready;
    assign last_cnt  = CNT_W'(step_of(mode_q, W0, W1, W2, OP_W) - 1);
    assign last_fire = out_fire && (cnt_q == last_cnt);

    assign out_data  = out_valid ? tap_data : '0;
    assign out_first = out_valid && (cnt_q == '0);
    assign out_last  = out_valid && (cnt_q == last_cnt);
    assign err       = err_q;

    mask_lane_tap #(
        .IP_W (IP_W),
        .OP_W (OP_W),
        .W0   (W0),
        .W1   (W1),
        .W2   (W2)
    ) u_lane_tap (
        .sh_i   (sh_q),
        .mode_i (mode_q),
        .data_o (tap_data)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_d   = in_fire && !in_legal;
`ifdef MASK_SER_PINGPONG_EN
        shadow_full_d = shadow_full_q;
        shadow_d      = shadow_q;
        shadow_mode_d = shadow_mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_fire && in_legal) begin
                    sh_d    = in_data;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_fire) begin
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                end
`ifdef MASK_SER_PINGPONG_EN
                if (last_fire && shadow_full_q) begin
                    sh_d          = shadow_q;
                    mode_d        = shadow_mode_q;
                    cnt_d         = '0;
                    shadow_full_d = 1'b0;
                end else if (last_fire && in_fire && in_legal) begin
                    // Empty shadow and a row arriving on the last beat: go straight to active.
                    sh_d   = in_data;
                    mode_d = in_mode;
                    cnt_d  = '0;
                end else if (last_fire) begin
                    state_d = IDLE;
                end
                if (in_fire && in_legal && !(last_fire && !shadow_full_q)) begin
                    shadow_d      = in_data;
                    shadow_mode_d = in_mode;
                    shadow_full_d = 1'b1;
                end
`else
                if (last_fire) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            mode_q  <= MODE_320;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef MASK_SER_PINGPONG_EN
            shadow_full_q <= 1'b0;
            shadow_q      <= '0;
            shadow_mode_q <= MODE_320;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef MASK_SER_PINGPONG_EN
            shadow_full_q <= shadow_full_d;
            shadow_q      <= shadow_d;
            shadow_mode_q <= shadow_mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_mask_stream_serializer.sv
// Directed, table-driven bench for mask_stream_serializer with hand-computed beats
// plus sequences for back-pressure, illegal mode, mid-row reset and ping-pong.
module tb_mask_stream_serializer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1079:0] in_data;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [19:0]   out_data;
    logic          out_first;
    logic          out_last;
    logic          busy;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MASK_SER_PINGPONG_EN
    localparam logic READY_WHILE_SHIFT = 1'b1;
`else
    localparam logic READY_WHILE_SHIFT = 1'b0;
`endif

    typedef struct {
        logic [1:0]  mode;
        int          s;
        bit          single;
        int          pos;
        int          hot_beat;
        logic [19:0] hot_val;
    } vec_t;

    vec_t vecs[7];

    mask_stream_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1079:0] build_row(input bit single, input int pos, input int s);
        logic [1079:0] r = '0;
        if (single) begin
            r[pos] = 1'b1;
        end else begin
            // Bits above the row width are set to prove they are ignored.
            for (int j = 0; j < 1080; j++) r[j] = (j < s * 20) ? (j % s == pos) : 1'b1;
        end
        return r;
    endfunction

    // Mode-1 row whose beat k carries the value k+1.
    function automatic logic [1079:0] count_row();
        logic [1079:0] r = '0;
        logic [19:0]   v;
        for (int k = 0; k < 32; k++) begin
            v = 20'(k + 1);
            for (int i = 0; i < 20; i++) r[i*32+k] = v[i];
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the input handshake.
    task automatic send_row(input string tag, input logic [1:0] mode, input logic [1079:0] data);
        int cyc = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect_row(input string tag, input int s, input int nbeats, input int hot_beat,
                               input logic [19:0] hot_val, input bit counting, input bit toggle);
        int          k = 0;
        int          cyc = 0;
        bit          stalled = 0;
        logic [19:0] held_data;
        logic        held_first, held_last;
        logic [19:0] exp;
        while (k < nbeats && cyc < 400) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            check($sformatf("%s cyc%0d valid", tag, cyc), 32'(out_valid), 32'd1);
            if (stalled) begin
                check($sformatf("%s hold data k%0d", tag, k), 32'(out_data), 32'(held_data));
                check($sformatf("%s hold first k%0d", tag, k), 32'(out_first), 32'(held_first));
                check($sformatf("%s hold last k%0d", tag, k), 32'(out_last), 32'(held_last));
                stalled = 0;
            end
            if (out_valid && out_ready) begin
                exp = counting ? 20'(k + 1) : ((k == hot_beat) ? hot_val : 20'h0);
                check($sformatf("%s beat%0d data", tag, k), 32'(out_data), 32'(exp));
                check($sformatf("%s beat%0d first", tag, k), 32'(out_first), 32'(k == 0));
                check($sformatf("%s beat%0d last", tag, k), 32'(out_last), 32'(k == s - 1));
                k++;
            end else if (out_valid) begin
                stalled    = 1;
                held_data  = out_data;
                held_first = out_first;
                held_last  = out_last;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, " beat count"}, 32'(k), 32'(nbeats));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_data"}, 32'(out_data), 32'd0);
        check({tag, " out_first"}, 32'(out_first), 32'd0);
        check({tag, " out_last"}, 32'(out_last), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 16, 1'b0, 3,    3,  20'hFFFFF};
        vecs[1] = '{2'd2, 54, 1'b1, 1079, 53, 20'h80000};
        vecs[2] = '{2'd1, 32, 1'b1, 0,    0,  20'h00001};
        vecs[3] = '{2'd1, 32, 1'b1, 167,  7,  20'h00020};
        vecs[4] = '{2'd0, 16, 1'b0, 15,   15, 20'hFFFFF};
        vecs[5] = '{2'd2, 54, 1'b0, 0,    0,  20'hFFFFF};
        vecs[6] = '{2'd2, 54, 1'b1, 560,  20, 20'h00400};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            send_row($sformatf("vec%0d", v), vecs[v].mode,
                     build_row(vecs[v].single, vecs[v].pos, vecs[v].s));
            check($sformatf("vec%0d in_ready shifting", v), 32'(in_ready), 32'(READY_WHILE_SHIFT));
            check($sformatf("vec%0d busy", v), 32'(busy), 32'd1);
            collect_row($sformatf("vec%0d", v), vecs[v].s, vecs[v].s, vecs[v].hot_beat,
                        vecs[v].hot_val, 1'b0, 1'b0);
            check($sformatf("vec%0d in_ready after last", v), 32'(in_ready), 32'd1);
            check($sformatf("vec%0d valid after last", v), 32'(out_valid), 32'd0);
        end

        // Back-pressure: ready toggles every cycle on a mode-1 row.
        send_row("bp", 2'd1, count_row());
        collect_row("bp", 32, 32, 0, 20'h0, 1'b1, 1'b1);
        check("bp valid after last", 32'(out_valid), 32'd0);
        check("bp busy after last", 32'(busy), 32'd0);

        // Illegal mode: accepted, dropped, one-cycle err.
        in_valid = 1'b1;
        in_mode  = 2'd3;
        in_data  = build_row(1'b0, 0, 16);
        check("illegal in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("illegal err pulse", 32'(err), 32'd1);
        check("illegal no valid", 32'(out_valid), 32'd0);
        check("illegal in_ready after", 32'(in_ready), 32'd1);
        check("illegal busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("illegal err cleared", 32'(err), 32'd0);
        check("illegal still no valid", 32'(out_valid), 32'd0);

        // Reset at beat 7 of a mode-1 row, then a fresh mode-0 row.
        send_row("rst", 2'd1, count_row());
        collect_row("rst pre", 32, 7, 0, 20'h0, 1'b1, 1'b0);
        check("rst beat7 presented", 32'(out_data), 32'd8);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrow reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset no valid", 32'(out_valid), 32'd0);
        send_row("post rst", 2'd0, build_row(1'b0, 3, 16));
        collect_row("post rst", 16, 16, 3, 20'hFFFFF, 1'b0, 1'b0);
        check("post rst valid after last", 32'(out_valid), 32'd0);

`ifdef MASK_SER_PINGPONG_EN
        // Mode-0 row then mode-1 row back to back: 48 beats, no bubble.
        send_row("pp row0", 2'd0, build_row(1'b0, 3, 16));
        for (int c = 0; c < 48; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                in_mode  = 2'd1;
                in_data  = count_row();
                check("pp shadow in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            check($sformatf("pp c%0d valid", c), 32'(out_valid), 32'd1);
            if (c < 16) begin
                check($sformatf("pp c%0d data", c), 32'(out_data), (c == 3) ? 32'hFFFFF : 32'd0);
            end else begin
                check($sformatf("pp c%0d data", c), 32'(out_data), 32'(c - 15));
            end
            check($sformatf("pp c%0d first", c), 32'(out_first), 32'(c == 0 || c == 16));
            check($sformatf("pp c%0d last", c), 32'(out_last), 32'(c == 15 || c == 47));
            @(negedge clk);
        end
        check("pp valid after both", 32'(out_valid), 32'd0);
        check("pp busy after both", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
